// File: rtl/sys_bridge_mp_pkg.sv
// Shared constants for the multi-slave system bridge:
// default windows, FSM encodings, store lane masks.
package sys_bridge_mp_pkg;

  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DM_END   = 32'h0000_2FFF;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] TC1_END  = 32'h0000_7F1B;
  localparam logic [31:0] TC2_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC2_END  = 32'h0000_7F0B;
  localparam logic [31:0] IG_BASE  = 32'h0000_7F20;
  localparam logic [31:0] IG_END   = 32'h0000_7F23;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [3:0] BE_HH = 4'b1100;
  localparam logic [3:0] BE_LH = 4'b0011;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_W  = 4'b1111;

endpackage

// File: rtl/sys_bridge_mp_lane_steer.sv
// Store lane steering: moves the low-aligned rt value
// onto the byte lanes named by byteen. Ports: byteen, wdata -> sdata.
module bridge_lane_steer
  import sys_bridge_mp_pkg::*;
(
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] sdata
);

  always_comb begin
    sdata = wdata;
    case (byteen)
      BE_HH:   sdata = {wdata[15:0], 16'h0};
      BE_B3:   sdata = {wdata[7:0], 24'h0};
      BE_B2:   sdata = {8'h0, wdata[7:0], 16'h0};
      BE_B1:   sdata = {16'h0, wdata[7:0], 8'h0};
      BE_LH,
      BE_B0,
      BE_W:    sdata = wdata;
      default: sdata = wdata;
    endcase
  end

endmodule

// File: rtl/sys_bridge_mp.sv
// Registered M-stage bridge to N address-windowed slaves with stall,
// timeout/unmapped fault and registered load return.
// Ports: clk/reset, cpu_* request/response, s_* slave side.
module sys_bridge_mp
  import sys_bridge_mp_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter logic [N_SLAVES*32-1:0] BASE  = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0] LIMIT = {N_SLAVES{32'h0}},
  parameter int TIMEOUT = 16,
  parameter int TW = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_byteen,
  input  logic                  cpu_kill,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_fault,
  output logic [N_SLAVES-1:0]   s_sel,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_byteen,
  input  logic [N_SLAVES*32-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]   s_ready
);

  logic [1:0]          state;
  logic [TW-1:0]       cnt;
  logic [N_SLAVES-1:0] hit_oh;
  logic                hit_any;
  logic [31:0]         steer;
  logic [31:0]         rd_mux;
  logic                rdy;
  logic                issue;

  bridge_lane_steer u_steer (
    .byteen (cpu_byteen),
    .wdata  (cpu_wdata),
    .sdata  (steer)
  );

  // Scan high to low so the lowest matching window wins.
  always_comb begin
    hit_oh  = '0;
    hit_any = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (cpu_addr >= BASE[i*32 +: 32] &&
          cpu_addr <= LIMIT[i*32 +: 32]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit_any   = 1'b1;
      end
    end
  end

  // s_sel is one-hot, so an and-or mux is enough.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      rd_mux = rd_mux | (s_rdata[i*32 +: 32] & {32{s_sel[i]}});
    end
  end

  assign rdy   = |(s_ready & s_sel);
  assign issue = cpu_req && !cpu_kill;

  assign cpu_stall  = (state == ST_IDLE && issue) ||
                      (state == ST_WAIT);
  assign cpu_rvalid = (state == ST_DONE) || (state == ST_ERR);
  assign cpu_fault  = (state == ST_ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      s_sel     <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_byteen  <= '0;
      cpu_rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (issue) begin
            if (hit_any) begin
              s_sel    <= hit_oh;
              s_addr   <= cpu_addr;
              s_wdata  <= steer;
              s_byteen <= cpu_byteen;
              cnt      <= '0;
              state    <= ST_WAIT;
            end else begin
              cpu_rdata <= '0;
              state     <= ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          if (rdy) begin
            cpu_rdata <= rd_mux;
            s_sel     <= '0;
            s_byteen  <= '0;
            state     <= ST_DONE;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            cpu_rdata <= '0;
            s_sel     <= '0;
            s_byteen  <= '0;
            state     <= ST_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sys_bridge_mp.md
Name: sys_bridge_mp

Overview:
- Parametrised successor to the CPU-side system bridge: M-stage memory accesses are routed to one of N_SLAVES address-windowed devices (DM, timers, interrupt generator, future peripherals).
- Adds what the combinational bridge lacks:
  - registered slave request with a valid/ready handshake;
  - CPU stall while a slave is pending;
  - bus-timeout and unmapped-address fault reporting;
  - registered load return.

Parameters:
- N_SLAVES, 4: number of slave windows.
- BASE, {N_SLAVES{32'h0}}: packed N_SLAVES*32 vector; window i start address (inclusive) = BASE[i*32+:32].
- LIMIT, {N_SLAVES{32'h0}}: packed N_SLAVES*32 vector; window i end address (inclusive).
- TIMEOUT, 16: maximum WAIT cycles before fault; range 1..2^TW-1.
- TW, 5: timeout counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  M-stage access valid.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  rt data, unaligned (low bits hold the value).
- cpu_byteen  in  4  store lane mask; 4'b0000 means load.
- cpu_kill  in  1  interrupt/exception in M; suppresses issue of the current access.
- cpu_stall  out  1  freeze pipeline.
- cpu_rvalid  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  registered load data, valid with cpu_rvalid.
- cpu_fault  out  1  one-cycle pulse: unmapped address or timeout.
- s_sel  out  N_SLAVES  one-hot slave request.
- s_addr  out  32  registered address.
- s_wdata  out  32  lane-steered store data.
- s_byteen  out  4  store mask; zero for loads.
- s_rdata  in  N_SLAVES*32  slave read data, slave i at [i*32+:32].
- s_ready  in  N_SLAVES  slave i has completed.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE;
  - s_sel, s_byteen, s_addr, s_wdata, cpu_rdata = 0;
  - cpu_rvalid, cpu_fault = 0;
  - timeout counter = 0.
  - Reset asserted in WAIT drops s_sel immediately; the transaction is discarded.
- Decode (combinational on cpu_addr):
  - hit[i] = BASE[i] <= addr <= LIMIT[i], unsigned.
  - Multiple hits: lowest index wins.
  - No hit: unmapped.
- Store steering, applied at issue:
  - 1100 -> {wdata[15:0], 16'h0}
  - 0011 -> wdata
  - 1000 -> {wdata[7:0], 24'h0}
  - 0100 -> {8'h0, wdata[7:0], 16'h0}
  - 0010 -> {16'h0, wdata[7:0], 8'h0}
  - 0001 and 1111 -> wdata
  - Any other mask: pass wdata unchanged with the mask unchanged.
- FSM states: IDLE, WAIT, DONE, ERR.
  - IDLE, cpu_req=1, cpu_kill=0, hit: register s_sel (one-hot), s_addr, s_wdata, s_byteen; counter=0; go to WAIT.
  - IDLE, cpu_req=1, cpu_kill=0, unmapped: go to ERR.
  - IDLE, cpu_kill=1: no issue; s_byteen is never nonzero for a killed access; stay IDLE.
  - WAIT, s_ready[sel]=1: cpu_rdata <= s_rdata[sel]; clear s_sel and s_byteen; go to DONE.
  - WAIT, counter == TIMEOUT-1 without ready: clear s_sel; go to ERR. Otherwise counter++.
  - WAIT, s_ready on a non-selected slave: ignored.
  - cpu_kill in WAIT: ignored; the issued access completes.
  - DONE: cpu_rvalid=1 for exactly one cycle; back to IDLE.
  - ERR: cpu_fault=1 and cpu_rvalid=1 for exactly one cycle; cpu_rdata=0; back to IDLE.
- cpu_stall = (IDLE & cpu_req & !cpu_kill) | WAIT. It is low in DONE/ERR so the pipeline advances on the rvalid cycle.
- Latency:
  - request accepted T0; s_sel high T1;
  - ready sampled at T1 -> rvalid at T2;
  - minimum 2 cycles, maximum TIMEOUT+1.
- A new cpu_req is accepted only in IDLE. Back-to-back requests are spaced ≥3 cycles.
- s_addr and s_wdata hold their last values when idle; only s_sel and s_byteen qualify them.

Decomposition:
- Shared package/define file holds:
  - default window constants: DM, TC1, TC2, INTGEN start/end;
  - FSM state encodings: IDLE=2'd0, WAIT=1, DONE=2, ERR=3;
  - store-steering mask constants.
- One natural sub-module: bridge_lane_steer (combinational cpu_byteen/cpu_wdata -> s_wdata). The FSM, decode and counter stay in sys_bridge_mp.

Test Plan:
- Load, DM window 0x0000_0000..0x0000_2FFF, addr 0x100, slave 0 ready on its 2nd sel cycle, s_rdata=0xDEADBEEF -> s_sel=0001 for 2 cycles; cpu_rvalid pulse with cpu_rdata=0xDEADBEEF; cpu_stall high exactly 3 cycles.
- Store sb, addr 0x7F02, byteen=0100, wdata=0x000000A5 -> TC2 slave selected; s_wdata=0x00A50000; s_byteen=0100.
- Store with cpu_kill=1 in the request cycle -> s_sel and s_byteen stay 0; no stall; no rvalid.
- Unmapped addr 0x9000_0000 -> state ERR next cycle; cpu_fault=1 and cpu_rvalid=1 for one cycle; cpu_rdata=0; s_sel never asserted.
- TIMEOUT=16 and slave never ready -> s_sel high 16 cycles, then fault pulse; next request accepted normally.
- reset driven low mid-WAIT -> s_sel=0 without a clock edge; after release, state IDLE and all outputs 0.
